amba_ahb_master: RTL and testbench
==================================

// Module: amba_ahb_master
// PURPOSE
//  AHB-Lite initiator that turns single-cycle commands (SINGLE or INCR4, read or write) into AHB bus
//  transfers with pipelined address/data phases. It drives amba_ahb_slave through dut_if, so the
//  slave can be checked against real master traffic. It honours HREADY wait states and the two-cycle
//  ERROR response, and reports per-beat read data plus per-command completion and error status.
// PARAMETERS
//  AW       32      address width (HADDR, cmd_addr)
//  DW       32      data width (HWDATA, HRDATA, wr_data, rd_data); legal HSIZE up to log2(DW/8)
//  HPROT_V  4'b0011 constant driven on HPROT (non-cacheable, privileged data access)
// PORTS
//  hclk      in   1   bus clock; all logic on rising edge
//  hreset    in   1   synchronous, active-high reset
//  cmd_valid in   1   command request
//  cmd_ready out  1   command accepted when cmd_valid && cmd_ready
//  cmd_write in   1   1=write, 0=read
//  cmd_addr  in   AW  start address
//  cmd_size  in   3   HSIZE encoding (0=byte, 1=half, 2=word)
//  cmd_incr4 in   1   1=INCR4 burst, 0=SINGLE
//  wr_data   in   DW  write data for the beat being issued
//  wr_pop    out  1   wr_data consumed this cycle; next beat must be on wr_data next cycle
//  rd_valid  out  1   rd_data valid (one pulse per read beat)
//  rd_data   out  DW  captured HRDATA
//  done      out  1   one-cycle pulse: command finished
//  done_err  out  1   qualifies done: ERROR response received or illegal command
//  hsel      out  1   1 while a command is active (single-slave systems, no external decoder)
//  haddr     out  AW  HADDR
//  htrans    out  2   HTRANS (IDLE=00, NONSEQ=10, SEQ=11; BUSY never driven)
//  hwrite    out  1   HWRITE
//  hsize     out  3   HSIZE
//  hburst    out  3   HBURST (SINGLE=000, INCR4=011)
//  hprot     out  4   HPROT = HPROT_V
//  hwdata    out  DW  HWDATA, registered, held for the whole data phase
//  hrdata    in   DW  HRDATA
//  hready    in   1   transfer done / wait state when low
//  hresp     in   1   0=OKAY, 1=ERROR
// BEHAVIOUR
//  Reset: all bus outputs 0 (htrans=IDLE); cmd_ready, wr_pop, rd_valid, done, done_err = 0; FSM=IDLE.
//  cmd_ready = (state==IDLE) && !hreset. Command fields are captured on acceptance.
//  FSM states:
//   IDLE -> ADDR on accept.
//   ADDR: beat n is on the bus (NONSEQ for beat0, SEQ after). It advances only while hready=1.
//     On hready=1: beat n enters its data phase, and beat n+1 goes on the address lines.
//     After the last beat's address: -> LAST.
//   LAST: htrans=IDLE. Hold until the last data phase completes with hready=1 -> DONE.
//   DONE: one-cycle state that pulses done. -> IDLE.
//   ERR: entered on hready=0 && hresp=1, i.e. cycle 1 of the ERROR response.
//     The next cycle drives htrans=IDLE and cancels any remaining beats.
//     Waits for the hready=1 cycle of the ERROR response, then pulses done with done_err=1. -> IDLE.
//  Address: beat n = cmd_addr + n*(1<<cmd_size), full AW-bit add. Beat addresses never cross 1KB.
//  Illegal command (rejected in the cycle after accept): no bus activity, done=done_err=1. Illegal means:
//   - cmd_addr not aligned to 1<<cmd_size;
//   - cmd_size > log2(DW/8);
//   - INCR4 crossing a 1KB boundary.
//  Latency, zero wait, SINGLE: accept T, address phase T+1, data phase T+2, done T+3.
//   INCR4: done T+6. Each wait state adds one cycle.
//  Writes: wr_pop pulses when a beat's address phase completes (hready=1).
//   hwdata <= wr_data on that edge and is held until the next pop.
//  Reads: rd_valid/rd_data are registered, 1 cycle after each data phase completes with hready=1, hresp=0.
//   A beat that completes with ERROR produces no rd_valid.
//  Address/control are held stable while hready=0. hsel=1 from the first address phase through the final data phase.
//  Reset mid-command: abort at once; bus outputs return to reset values next edge; no done pulse.
// STRUCTURE
//  ahb_pkg: htrans_t, hburst_t, hsize constants, HRESP_OKAY/HRESP_ERROR, the 1KB boundary constant.
//  Sub-module ahb_burst_addr_gen: beat counter and address incrementer, plus the alignment and 1KB legality check.
//  The FSM stays in amba_ahb_master.
// TESTING
//  1. Write SINGLE: addr 0x10, size 2, wr_data 0xDEADBEEF, hready=1 -> NONSEQ at T+1, hwdata 0xDEADBEEF at T+2, done at T+3.
//  2. Read INCR4 from 0x100 -> haddr 0x100/104/108/10C with NONSEQ,SEQ,SEQ,SEQ; 4 rd_valid pulses in order; done at T+6.
//  3. Slave inserts 2 wait states on beat 1 of a write INCR4 -> haddr/htrans/hwdata held stable; done at T+8; exactly 4 wr_pop.
//  4. ERROR on beat 2 of read INCR4 -> htrans=IDLE the cycle after ERROR cycle 1; beat 3 never issued; done=done_err=1; 2 rd_valid.
//  5. INCR4 at 0x3F8 size 2 (crosses 1KB), and size-2 addr 0x2 -> htrans stays IDLE; done=done_err=1 at T+1.
//  6. hreset=1 during beat 1 of an INCR4 -> next edge htrans=IDLE, haddr=0; no done; the next command runs normally.

Source files
------------

// File: rtl/amba_ahb_master_pkg.sv
// Shared AHB-Lite encodings, the FSM state type and burst constants for the initiator.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package amba_ahb_master_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR4  = 3'b011
    } hburst_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Bursts may not cross a 1KB address boundary.
    localparam int unsigned KB_SHIFT    = 10;
    localparam int unsigned KB_BOUNDARY = 1 << KB_SHIFT;

    localparam int unsigned INCR4_BEATS = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LAST,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/amba_ahb_master_if.sv
// Command, write/read data and AHB-Lite bus signals between the initiator and its environment.
// Latency: none (wiring only).
// Backpressure: cmd_valid/cmd_ready on commands; hready stalls the bus.
interface amba_ahb_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    import amba_ahb_master_pkg::*;

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [2:0]    cmd_size;
    logic          cmd_incr4;
    logic [DW-1:0] wr_data;
    logic          wr_pop;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          done_err;

    logic          hsel;
    logic [AW-1:0] haddr;
    htrans_t       htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    hburst_t       hburst;
    logic [3:0]    hprot;
    logic [DW-1:0] hwdata;
    logic [DW-1:0] hrdata;
    logic          hready;
    logic          hresp;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_incr4, wr_data,
        input  hrdata, hready, hresp,
        output cmd_ready, wr_pop, rd_valid, rd_data, done, done_err,
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_incr4, wr_data,
        output hrdata, hready, hresp,
        input  cmd_ready, wr_pop, rd_valid, rd_data, done, done_err,
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata
    );

endinterface

// File: rtl/amba_ahb_master_burst_addr_gen.sv
// Beat counter, beat address incrementer and command legality check (alignment, size, 1KB).
// Latency: command captured on load_i, legality and first address valid the next cycle.
// Backpressure: advances only on adv_i, which the FSM raises when an address phase completes.
module ahb_burst_addr_gen
    import amba_ahb_master_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          load_i,
    input  logic          adv_i,
    input  logic [AW-1:0] cmd_addr_i,
    input  logic [2:0]    cmd_size_i,
    input  logic          cmd_incr4_i,
    output logic [AW-1:0] addr_o,
    output logic [2:0]    size_o,
    output logic          incr4_o,
    output logic [1:0]    beat_o,
    output logic          last_o,
    output logic          legal_o
);

    localparam int MAX_SIZE = $clog2(DW / 8);

    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    size_q, size_d;
    logic          incr4_q, incr4_d;
    logic [1:0]    beat_q, beat_d;
    logic          legal_q, legal_d;

    logic [AW-1:0] cmd_step;
    logic [AW-1:0] cmd_end;
    logic          cmd_aligned;
    logic          cmd_size_ok;
    logic          cmd_cross;
    logic [AW-1:0] step_q;

    // Legality of the incoming command, judged on the raw command fields at accept time.
    always_comb begin
        cmd_step    = AW'(1) << cmd_size_i;
        cmd_end     = cmd_addr_i + (cmd_step << 1) + cmd_step;
        cmd_aligned = (cmd_addr_i & (cmd_step - AW'(1))) == '0;
        cmd_size_ok = int'(cmd_size_i) <= MAX_SIZE;
        cmd_cross   = cmd_incr4_i && ((cmd_addr_i >> KB_SHIFT) != (cmd_end >> KB_SHIFT));
        legal_d     = cmd_aligned && cmd_size_ok && !cmd_cross;
    end

    assign step_q = AW'(1) << size_q;

    // Capture a new command on load, otherwise step to the next beat on each completed address phase.
    always_comb begin
        addr_d  = addr_q;
        size_d  = size_q;
        incr4_d = incr4_q;
        beat_d  = beat_q;
        if (load_i) begin
            addr_d  = cmd_addr_i;
            size_d  = cmd_size_i;
            incr4_d = cmd_incr4_i;
            beat_d  = 2'd0;
        end else if (adv_i) begin
            addr_d  = addr_q + step_q;
            beat_d  = beat_q + 2'd1;
        end
    end

    // Beat state registers; reset returns haddr to zero.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            addr_q  <= '0;
            size_q  <= 3'd0;
            incr4_q <= 1'b0;
            beat_q  <= 2'd0;
            legal_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            size_q  <= size_d;
            incr4_q <= incr4_d;
            beat_q  <= beat_d;
            if (load_i) begin
                legal_q <= legal_d;
            end
        end
    end

    assign addr_o  = addr_q;
    assign size_o  = size_q;
    assign incr4_o = incr4_q;
    assign beat_o  = beat_q;
    assign last_o  = incr4_q ? (beat_q == 2'(INCR4_BEATS - 1)) : 1'b1;
    assign legal_o = legal_q;

endmodule

// File: rtl/amba_ahb_master.sv
// AHB-Lite initiator: SINGLE/INCR4 read/write commands become pipelined address/data phases.
// Latency: SINGLE done 3 cycles after accept, INCR4 done 6, plus one per wait state.
// Backpressure: one command in flight (cmd_ready only in IDLE); hready low freezes address and data.
module amba_ahb_master
    import amba_ahb_master_pkg::*;
#(
    parameter int         AW      = 32,
    parameter int         DW      = 32,
    parameter logic [3:0] HPROT_V = 4'b0011
) (
    input  logic               hclk,
    input  logic               hreset,
    amba_ahb_master_if.master  bus
);

    state_t        state_q, state_d;
    logic          err_q, err_d;
    logic          dph_q, dph_d;
    logic          write_q;
    logic          rd_valid_q;
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] hwdata_q;

    logic          load;
    logic          adv;
    logic          rd_fire;
    logic          cmd_ready;
    logic          wr_pop;
    logic          done;
    logic          done_err;
    logic          hsel;
    htrans_t       htrans;

    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic          incr4;
    logic [1:0]    beat;
    logic          last;
    logic          legal;

    ahb_burst_addr_gen #(
        .AW (AW),
        .DW (DW)
    ) u_addr_gen (
        .hclk        (hclk),
        .hreset      (hreset),
        .load_i      (load),
        .adv_i       (adv),
        .cmd_addr_i  (bus.cmd_addr),
        .cmd_size_i  (bus.cmd_size),
        .cmd_incr4_i (bus.cmd_incr4),
        .addr_o      (addr),
        .size_o      (size),
        .incr4_o     (incr4),
        .beat_o      (beat),
        .last_o      (last),
        .legal_o     (legal)
    );

    // Next-state and per-cycle bus/handshake outputs of the transfer FSM.
    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        load      = 1'b0;
        adv       = 1'b0;
        cmd_ready = 1'b0;
        wr_pop    = 1'b0;
        done      = 1'b0;
        done_err  = 1'b0;
        hsel      = 1'b0;
        htrans    = HTRANS_IDLE;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = !hreset;
                if (bus.cmd_valid && !hreset) begin
                    load    = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (!legal) begin
                    // Rejected before any address phase reaches the bus.
                    done     = 1'b1;
                    done_err = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    hsel   = 1'b1;
                    htrans = (beat == 2'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
                    if (dph_q && !bus.hready && (bus.hresp == HRESP_ERROR)) begin
                        state_d = S_ERR;
                    end else if (bus.hready) begin
                        adv    = 1'b1;
                        wr_pop = write_q;
                        if (last) begin
                            state_d = S_LAST;
                        end
                    end
                end
            end
            S_LAST: begin
                hsel = 1'b1;
                if (!bus.hready && (bus.hresp == HRESP_ERROR)) begin
                    state_d = S_ERR;
                end else if (bus.hready) begin
                    state_d = S_DONE;
                end
            end
            S_ERR: begin
                // Second ERROR cycle: remaining beats are dropped, htrans already IDLE.
                hsel = 1'b1;
                if (bus.hready) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                done_err = err_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A data phase is outstanding from a completed address phase until hready ends it.
    assign dph_d   = adv ? 1'b1 : (bus.hready ? 1'b0 : dph_q);
    assign rd_fire = dph_q && bus.hready && (bus.hresp == HRESP_OKAY) && !write_q;

    // State, data-phase tracking, registered read return and held write data.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= S_IDLE;
            err_q      <= 1'b0;
            dph_q      <= 1'b0;
            write_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            hwdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            dph_q      <= dph_d;
            rd_valid_q <= rd_fire;
            if (load) begin
                write_q <= bus.cmd_write;
            end
            if (rd_fire) begin
                rd_data_q <= bus.hrdata;
            end
            if (wr_pop) begin
                hwdata_q <= bus.wr_data;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.wr_pop    = wr_pop;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.done      = done;
    assign bus.done_err  = done_err;
    assign bus.hsel      = hsel;
    assign bus.haddr     = addr;
    assign bus.htrans    = htrans;
    assign bus.hwrite    = hsel && write_q;
    assign bus.hsize     = hsel ? size : 3'd0;
    assign bus.hburst    = (hsel && incr4) ? HBURST_INCR4 : HBURST_SINGLE;
    assign bus.hprot     = hsel ? HPROT_V : 4'd0;
    assign bus.hwdata    = hwdata_q;

endmodule

// File: tb/tb_amba_ahb_master.sv
// Directed bench for amba_ahb_master: single/burst reads and writes, wait states, ERROR, illegal commands, reset.
// Latency: checks each cycle 2ns after the rising edge.
// Backpressure: bench drives hready/hresp directly per cycle.
module tb_amba_ahb_master;
    import amba_ahb_master_pkg::*;

    logic hclk = 1'b0;
    logic hreset;
    int   checks = 0;
    int   errors = 0;
    int   pops;
    int   rds;

    amba_ahb_master_if #(.AW(32), .DW(32)) bus ();

    amba_ahb_master #(
        .AW      (32),
        .DW      (32),
        .HPROT_V (4'b0011)
    ) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    // Present a command in the current cycle; returns one cycle later (address phase cycle).
    task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] s,
                         input logic i4, input logic [31:0] wd);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_size  = s;
        bus.cmd_incr4 = i4;
        bus.wr_data   = wd;
        #1;
        chk("issue_cmd_ready", bus.cmd_ready, 1);
        cyc();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        hreset        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_size  = 3'd0;
        bus.cmd_incr4 = 1'b0;
        bus.wr_data   = '0;
        bus.hrdata    = '0;
        bus.hready    = 1'b1;
        bus.hresp     = 1'b0;
        repeat (2) cyc();
        #1;
        chk("rst_htrans",    bus.htrans, 0);
        chk("rst_haddr",     bus.haddr, 0);
        chk("rst_hsel",      bus.hsel, 0);
        chk("rst_hprot",     bus.hprot, 0);
        chk("rst_hwdata",    bus.hwdata, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_done",      bus.done, 0);
        chk("rst_rd_valid",  bus.rd_valid, 0);
        chk("rst_wr_pop",    bus.wr_pop, 0);
        hreset = 1'b0;
        #1;
        chk("rst_release_ready", bus.cmd_ready, 1);

        // 1: write SINGLE
        issue(1'b1, 32'h10, 3'd2, 1'b0, 32'hDEADBEEF);
        #1;
        chk("t1_htrans", bus.htrans, 2'b10);
        chk("t1_haddr",  bus.haddr, 32'h10);
        chk("t1_hwrite", bus.hwrite, 1);
        chk("t1_hsize",  bus.hsize, 2);
        chk("t1_hburst", bus.hburst, 0);
        chk("t1_hsel",   bus.hsel, 1);
        chk("t1_hprot",  bus.hprot, 4'b0011);
        chk("t1_wr_pop", bus.wr_pop, 1);
        cyc(); #1;
        chk("t1_hwdata",    bus.hwdata, 32'hDEADBEEF);
        chk("t1_idle",      bus.htrans, 0);
        chk("t1_hsel_data", bus.hsel, 1);
        chk("t1_early",     bus.done, 0);
        cyc(); #1;
        chk("t1_done",     bus.done, 1);
        chk("t1_done_err", bus.done_err, 0);
        cyc(); #1;
        chk("t1_done_clr", bus.done, 0);
        chk("t1_ready",    bus.cmd_ready, 1);

        // 2: read INCR4 from 0x100, zero wait
        issue(1'b0, 32'h100, 3'd2, 1'b1, 32'h0);
        for (int n = 0; n < 6; n++) begin
            bus.hrdata = 32'hA000_0000 + 32'(n - 1);
            #1;
            if (n < 4) begin
                chk("t2_haddr",  bus.haddr, 32'h100 + 32'(4 * n));
                chk("t2_htrans", bus.htrans, (n == 0) ? 2'b10 : 2'b11);
                chk("t2_hburst", bus.hburst, 3'b011);
            end else if (n == 4) begin
                chk("t2_last_idle", bus.htrans, 0);
            end
            chk("t2_rd_valid", bus.rd_valid, n >= 2);
            if (n >= 2) chk("t2_rd_data", bus.rd_data, 32'hA000_0000 + 32'(n - 2));
            chk("t2_done", bus.done, n == 5);
            cyc();
        end

        // 3: write INCR4, two wait states on the data phase of beat 1
        begin
            int abeat[6];
            logic [31:0] hw_exp[8];
            abeat  = '{0, 1, 2, 2, 2, 3};
            hw_exp = '{32'h0, 32'h5000_0000, 32'h5000_0001, 32'h5000_0001,
                       32'h5000_0001, 32'h5000_0002, 32'h5000_0003, 32'h5000_0003};
            pops = 0;
            issue(1'b1, 32'h200, 3'd2, 1'b1, 32'h5000_0000);
            for (int n = 0; n < 8; n++) begin
                bus.hready = !(n == 2 || n == 3);
                if (n < 6) bus.wr_data = 32'h5000_0000 + 32'(abeat[n]);
                #1;
                if (n < 6) begin
                    chk("t3_haddr",  bus.haddr, 32'h200 + 32'(4 * abeat[n]));
                    chk("t3_htrans", bus.htrans, (n == 0) ? 2'b10 : 2'b11);
                end else if (n == 6) begin
                    chk("t3_last_idle", bus.htrans, 0);
                end
                if (n >= 1) chk("t3_hwdata", bus.hwdata, hw_exp[n]);
                if (bus.wr_pop) pops++;
                chk("t3_done", bus.done, n == 7);
                cyc();
            end
            bus.hready = 1'b1;
            chk("t3_pops", pops, 4);
        end

        // 4: ERROR on beat 2 of read INCR4
        rds = 0;
        issue(1'b0, 32'h300, 3'd2, 1'b1, 32'h0);
        for (int n = 0; n < 7; n++) begin
            bus.hready = (n != 3);
            bus.hresp  = (n == 3 || n == 4);
            bus.hrdata = 32'hB000_0000 + 32'(n - 1);
            #1;
            if (n < 4) begin
                chk("t4_haddr",  bus.haddr, 32'h300 + 32'(4 * n));
                chk("t4_htrans", bus.htrans, (n == 0) ? 2'b10 : 2'b11);
            end else if (n == 4) begin
                chk("t4_err_idle", bus.htrans, 0);
                chk("t4_err_hsel", bus.hsel, 1);
            end
            if (bus.rd_valid) rds++;
            if (n == 2 || n == 3) chk("t4_rd_data", bus.rd_data, 32'hB000_0000 + 32'(n - 2));
            chk("t4_done", bus.done, n == 5);
            if (n == 5) chk("t4_done_err", bus.done_err, 1);
            if (n == 6) chk("t4_ready", bus.cmd_ready, 1);
            cyc();
        end
        bus.hready = 1'b1;
        bus.hresp  = 1'b0;
        chk("t4_rd_count", rds, 2);

        // 5: illegal commands rejected at T+1, plus a legal burst ending just below 1KB
        issue(1'b0, 32'h3F8, 3'd2, 1'b1, 32'h0);
        #1;
        chk("t5a_htrans",   bus.htrans, 0);
        chk("t5a_hsel",     bus.hsel, 0);
        chk("t5a_done",     bus.done, 1);
        chk("t5a_done_err", bus.done_err, 1);
        cyc(); #1;
        chk("t5a_done_clr", bus.done, 0);
        issue(1'b1, 32'h2, 3'd2, 1'b0, 32'h1234);
        #1;
        chk("t5b_htrans",   bus.htrans, 0);
        chk("t5b_wr_pop",   bus.wr_pop, 0);
        chk("t5b_done",     bus.done, 1);
        chk("t5b_done_err", bus.done_err, 1);
        cyc(); #1;
        issue(1'b0, 32'h0, 3'd3, 1'b0, 32'h0);
        #1;
        chk("t5c_done_err", bus.done_err, 1);
        chk("t5c_htrans",   bus.htrans, 0);
        cyc(); #1;
        issue(1'b0, 32'h3F0, 3'd2, 1'b1, 32'h0);
        for (int n = 0; n < 6; n++) begin
            #1;
            if (n < 4) chk("t5d_haddr", bus.haddr, 32'h3F0 + 32'(4 * n));
            chk("t5d_done", bus.done, n == 5);
            if (n == 5) chk("t5d_done_err", bus.done_err, 0);
            cyc();
        end

        // 6: reset during beat 1 of an INCR4, then a normal command
        issue(1'b0, 32'h400, 3'd2, 1'b1, 32'h0);
        #1;
        chk("t6_nonseq", bus.htrans, 2'b10);
        chk("t6_haddr0", bus.haddr, 32'h400);
        cyc();
        hreset = 1'b1;
        #1;
        chk("t6_seq", bus.htrans, 2'b11);
        cyc();
        hreset = 1'b0;
        #1;
        chk("t6_rst_htrans",   bus.htrans, 0);
        chk("t6_rst_haddr",    bus.haddr, 0);
        chk("t6_rst_hsel",     bus.hsel, 0);
        chk("t6_rst_rd_valid", bus.rd_valid, 0);
        chk("t6_rst_ready",    bus.cmd_ready, 1);
        for (int n = 0; n < 3; n++) begin
            chk("t6_no_done", bus.done, 0);
            cyc();
        end
        issue(1'b0, 32'h20, 3'd2, 1'b0, 32'h0);
        #1;
        chk("t6_new_htrans", bus.htrans, 2'b10);
        chk("t6_new_haddr",  bus.haddr, 32'h20);
        cyc();
        bus.hrdata = 32'hC0FF_EE00;
        #1;
        cyc(); #1;
        chk("t6_new_done",     bus.done, 1);
        chk("t6_new_done_err", bus.done_err, 0);
        chk("t6_new_rd_valid", bus.rd_valid, 1);
        chk("t6_new_rd_data",  bus.rd_data, 32'hC0FF_EE00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
